// File: rtl/branch_predictor_btb_if.sv
// Fetch/decode-side signal bundle between the MIPS pipeline and the BTB predictor.
// The pipeline (master) drives the fetch PC and the decode-stage resolution;
// the predictor (slave) returns the prediction, the flush request and counters.
interface branch_predictor_btb_if;
  logic [31:0] PCF;
  logic        StallD;
  logic        FlushD;
  logic        BranchD;
  logic        TakenD;
  logic [31:0] BranchTargetD;
  logic        HitF;
  logic        PredTakenF;
  logic [31:0] PredPCF;
  logic        flushbp;
  logic [31:0] RedirectPCD;
  logic [31:0] BranchCount;
  logic [31:0] MispredCount;

  modport master (
    output PCF, StallD, FlushD, BranchD, TakenD, BranchTargetD,
    input  HitF, PredTakenF, PredPCF, flushbp, RedirectPCD, BranchCount, MispredCount
  );

  modport slave (
    input  PCF, StallD, FlushD, BranchD, TakenD, BranchTargetD,
    output HitF, PredTakenF, PredPCF, flushbp, RedirectPCD, BranchCount, MispredCount
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch-target buffer with per-entry saturating counters.
// Fetch looks up combinationally; decode resolves one cycle later, updates the
// entry and, on a wrong guess, raises flushbp with the corrected fetch PC.
module branch_predictor_btb #(
  parameter int IDX_W    = 5,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 2 ** (CTR_W - 1)
) (
  input logic                  clk,
  input logic                  reset,
  branch_predictor_btb_if.slave bp
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  // Table storage: kept in flops because the lookup must be same-cycle.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  // Fetch -> decode register.
  logic        vd_q,      vd_d;
  logic [31:0] pcd_q,     pcd_d;
  logic        predd_q,   predd_d;
  logic [31:0] predpcd_q, predpcd_d;

  // Performance counters.
  logic [31:0] branch_cnt_q,  branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // ---------------------------------------------------------------- fetch lookup
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;
  logic             pred_taken_f;
  logic [31:0]      pred_pc_f;

  assign idx_f        = bp.PCF[IDX_W+1:2];
  assign tag_f        = bp.PCF[31:IDX_W+2];
  assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f = hit_f && ctr_q[idx_f][CTR_W-1];
  assign pred_pc_f    = pred_taken_f ? target_q[idx_f] : (bp.PCF + 32'd4);

  assign bp.HitF       = hit_f;
  assign bp.PredTakenF = pred_taken_f;
  assign bp.PredPCF    = pred_pc_f;

  // ---------------------------------------------------------------- decode resolve
  // A pending resolution is discarded while reset is asserted.
  logic             res;
  logic [IDX_W-1:0] idx_dec;
  logic [TAG_W-1:0] tag_dec;
  logic             hit_dec;
  logic [CTR_W-1:0] ctr_dec;

  assign res     = vd_q && !bp.StallD && !reset;
  assign idx_dec = pcd_q[IDX_W+1:2];
  assign tag_dec = pcd_q[31:IDX_W+2];
  assign hit_dec = valid_q[idx_dec] && (tag_q[idx_dec] == tag_dec);
  assign ctr_dec = ctr_q[idx_dec];

  // One-hot select of the entry addressed by the decode PC.
  logic [ENTRIES-1:0] sel_dec;
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_sel
      assign sel_dec[gi] = (idx_dec == IDX_W'(gi));
    end
  endgenerate

  // Misprediction detection and redirect target.
  logic        flush;
  logic [31:0] redirect_pc;

  always_comb begin
    flush       = 1'b0;
    redirect_pc = 32'd0;
    if (res) begin
      if (bp.BranchD && bp.TakenD && (!predd_q || (predpcd_q != bp.BranchTargetD))) begin
        flush       = 1'b1;
        redirect_pc = bp.BranchTargetD;
      end else if (bp.BranchD && !bp.TakenD && predd_q) begin
        flush       = 1'b1;
        redirect_pc = pcd_q + 32'd4;
      end else if (!bp.BranchD && predd_q) begin
        // Non-branch predicted taken: aliased or stale entry.
        flush       = 1'b1;
        redirect_pc = pcd_q + 32'd4;
      end
    end
  end

  assign bp.flushbp     = flush;
  assign bp.RedirectPCD = redirect_pc;

  // Table write for the entry at the decode index (counter train, allocate, invalidate).
  logic             wr_en;
  logic             wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [31:0]      wr_target;
  logic [CTR_W-1:0] wr_ctr;

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = valid_q[idx_dec];
    wr_tag    = tag_q[idx_dec];
    wr_target = target_q[idx_dec];
    wr_ctr    = ctr_dec;
    if (res) begin
      if (bp.BranchD) begin
        if (hit_dec) begin
          wr_en = 1'b1;
          if (bp.TakenD) begin
            wr_ctr    = (ctr_dec == CTR_MAX) ? ctr_dec : (ctr_dec + CTR_ONE);
            wr_target = bp.BranchTargetD;
          end else begin
            wr_ctr = (ctr_dec == CTR_ZERO) ? ctr_dec : (ctr_dec - CTR_ONE);
          end
        end else if (bp.TakenD) begin
          wr_en     = 1'b1;
          wr_valid  = 1'b1;
          wr_tag    = tag_dec;
          wr_target = bp.BranchTargetD;
          wr_ctr    = CTR_INIT;
        end
      end else if (predd_q && hit_dec) begin
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  // Table state register: cleared on reset, otherwise written at the selected entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_INIT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_en && sel_dec[i]) begin
          valid_q[i]  <= wr_valid;
          tag_q[i]    <= wr_tag;
          target_q[i] <= wr_target;
          ctr_q[i]    <= wr_ctr;
        end
      end
    end
  end

  // Next-state for the decode register and the performance counters.
  always_comb begin
    vd_d          = vd_q;
    pcd_d         = pcd_q;
    predd_d       = predd_q;
    predpcd_d     = predpcd_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bp.FlushD) begin
      vd_d = 1'b0;
    end else if (!bp.StallD) begin
      vd_d      = 1'b1;
      pcd_d     = bp.PCF;
      predd_d   = pred_taken_f;
      predpcd_d = pred_pc_f;
    end
    if (res && bp.BranchD) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (flush) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // Decode register and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      vd_q          <= 1'b0;
      pcd_q         <= '0;
      predd_q       <= 1'b0;
      predpcd_q     <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      vd_q          <= vd_d;
      pcd_q         <= pcd_d;
      predd_q       <= predd_d;
      predpcd_q     <= predpcd_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bp.BranchCount  = branch_cnt_q;
  assign bp.MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: a behavioural BTB model checked every
// cycle, plus hand-computed literal expectations along the scenario.
module tb_branch_predictor_btb;
  localparam int IDX_W   = 5;
  localparam int CTR_W   = 2;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int CMAX    = (1 << CTR_W) - 1;
  localparam int CINIT   = 1 << (CTR_W - 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_btb_if bp_if ();

  branch_predictor_btb #(.IDX_W(IDX_W), .CTR_W(CTR_W), .INIT_CTR(CINIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bp_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ behavioural model
  bit          m_v   [ENTRIES];
  bit [31:0]   m_tag [ENTRIES];
  bit [31:0]   m_tgt [ENTRIES];
  int          m_ctr [ENTRIES];
  bit          m_dv;
  bit [31:0]   m_dpc;
  bit          m_dpred;
  bit [31:0]   m_dppc;
  bit [31:0]   m_bc;
  bit [31:0]   m_mc;
  bit          m_ready = 1'b0;

  always @(negedge clk) begin : compare
    bit [31:0] pc, ppc, redir, e_tag, d_tag;
    int        idx, didx;
    bit        hit, pt, res, taken, mis, dhit;

    pc    = bp_if.PCF;
    idx   = int'((pc >> 2) & (ENTRIES - 1));
    e_tag = pc >> (IDX_W + 2);
    hit   = m_v[idx] && (m_tag[idx] == e_tag);
    pt    = hit && (m_ctr[idx] >= CINIT);
    ppc   = pt ? m_tgt[idx] : pc + 32'd4;

    // The decode instruction mispredicted if its guessed direction differs from
    // the real one, or it went the right way to the wrong address.
    res   = m_dv && !bp_if.StallD && !reset;
    taken = bp_if.BranchD && bp_if.TakenD;
    mis   = res && ((m_dpred != taken) || (taken && (m_dppc != bp_if.BranchTargetD)));
    redir = !mis ? 32'd0 : (taken ? bp_if.BranchTargetD : m_dpc + 32'd4);

    if (m_ready) begin
      chk("HitF", bp_if.HitF, hit);
      chk("PredTakenF", bp_if.PredTakenF, pt);
      chk("PredPCF", bp_if.PredPCF, ppc);
      chk("flushbp", bp_if.flushbp, mis);
      chk("RedirectPCD", bp_if.RedirectPCD, redir);
      chk("BranchCount", bp_if.BranchCount, m_bc);
      chk("MispredCount", bp_if.MispredCount, m_mc);
    end

    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = CINIT;
      end
      m_dv = 0; m_dpc = 0; m_dpred = 0; m_dppc = 0; m_bc = 0; m_mc = 0;
      m_ready = 1'b1;
    end else begin
      if (res) begin
        didx  = int'((m_dpc >> 2) & (ENTRIES - 1));
        d_tag = m_dpc >> (IDX_W + 2);
        dhit  = m_v[didx] && (m_tag[didx] == d_tag);
        if (bp_if.BranchD) begin
          m_bc++;
          if (dhit) begin
            if (bp_if.TakenD) begin
              if (m_ctr[didx] < CMAX) m_ctr[didx]++;
              m_tgt[didx] = bp_if.BranchTargetD;
            end else if (m_ctr[didx] > 0) begin
              m_ctr[didx]--;
            end
          end else if (bp_if.TakenD) begin
            m_v[didx] = 1; m_tag[didx] = d_tag;
            m_tgt[didx] = bp_if.BranchTargetD; m_ctr[didx] = CINIT;
          end
        end else if (m_dpred && dhit) begin
          m_v[didx] = 0;
        end
        if (mis) m_mc++;
      end
      if (bp_if.FlushD) begin
        m_dv = 0;
      end else if (!bp_if.StallD) begin
        m_dv = 1; m_dpc = pc; m_dpred = pt; m_dppc = ppc;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  // One cycle: drive inputs just after the edge, leave 1 time unit to settle.
  task automatic cyc(input logic [31:0] pc, input logic br, input logic tk,
                     input logic [31:0] tgt, input logic stall = 1'b0,
                     input logic fl = 1'b0, input logic rst = 1'b0);
    @(posedge clk);
    #1;
    reset               = rst;
    bp_if.PCF           = pc;
    bp_if.BranchD       = br;
    bp_if.TakenD        = tk;
    bp_if.BranchTargetD = tgt;
    bp_if.StallD        = stall;
    bp_if.FlushD        = fl;
    #1;
    $display("t=%0t PCF=%08h br=%0b tk=%0b tgt=%08h st=%0b fl=%0b rst=%0b -> hit=%0b pt=%0b ppc=%08h flush=%0b redir=%08h bc=%0d mc=%0d",
             $time, pc, br, tk, tgt, stall, fl, rst, bp_if.HitF, bp_if.PredTakenF,
             bp_if.PredPCF, bp_if.flushbp, bp_if.RedirectPCD, bp_if.BranchCount, bp_if.MispredCount);
  endtask

  initial begin
    reset               = 1'b1;
    bp_if.PCF           = 32'h40;
    bp_if.StallD        = 1'b0;
    bp_if.FlushD        = 1'b0;
    bp_if.BranchD       = 1'b0;
    bp_if.TakenD        = 1'b0;
    bp_if.BranchTargetD = 32'h0;

    cyc(32'h40, 0, 0, 0, 0, 0, 1);
    // C1: reset state
    cyc(32'h40, 0, 0, 0);
    chk("rst HitF", bp_if.HitF, 0);
    chk("rst PredPCF", bp_if.PredPCF, 32'h44);
    chk("rst flushbp", bp_if.flushbp, 0);
    chk("rst BranchCount", bp_if.BranchCount, 0);
    chk("rst MispredCount", bp_if.MispredCount, 0);
    // C2: first taken branch at 0x40 -> allocation miss
    cyc(32'h300, 1, 1, 32'h80);
    chk("alloc flushbp", bp_if.flushbp, 1);
    chk("alloc RedirectPCD", bp_if.RedirectPCD, 32'h80);
    // C3: refetch hits
    cyc(32'h40, 0, 0, 0);
    chk("hit HitF", bp_if.HitF, 1);
    chk("hit PredTakenF", bp_if.PredTakenF, 1);
    chk("hit PredPCF", bp_if.PredPCF, 32'h80);
    chk("hit counts bc", bp_if.BranchCount, 1);
    chk("hit counts mc", bp_if.MispredCount, 1);
    // C4: not taken while predicted taken
    cyc(32'h300, 1, 0, 0);
    chk("nt1 flushbp", bp_if.flushbp, 1);
    chk("nt1 RedirectPCD", bp_if.RedirectPCD, 32'h44);
    // C5-C6: now predicted not taken, no flush
    cyc(32'h40, 0, 0, 0);
    chk("nt2 PredTakenF", bp_if.PredTakenF, 0);
    chk("nt2 PredPCF", bp_if.PredPCF, 32'h44);
    cyc(32'h300, 1, 0, 0);
    chk("nt2 flushbp", bp_if.flushbp, 0);
    // C7-C8: third not-taken saturates at 0
    cyc(32'h40, 0, 0, 0);
    cyc(32'h300, 1, 0, 0);
    chk("nt3 flushbp", bp_if.flushbp, 0);
    // C9-C10: taken from 0 -> 1, still predicts not taken next time
    cyc(32'h40, 0, 0, 0);
    cyc(32'h300, 1, 1, 32'h80);
    chk("sat0 flushbp", bp_if.flushbp, 1);
    cyc(32'h40, 0, 0, 0);
    chk("sat0 PredTakenF", bp_if.PredTakenF, 0);
    // C12-C13: taken again -> 2, predicts taken
    cyc(32'h300, 1, 1, 32'h80);
    cyc(32'h40, 0, 0, 0);
    chk("ctr2 PredTakenF", bp_if.PredTakenF, 1);
    // C14: alias fetch 0x40+4*ENTRIES, decode resolves 0x40 correctly
    cyc(32'h40 + 4 * ENTRIES, 1, 1, 32'h80);
    chk("alias HitF", bp_if.HitF, 0);
    chk("alias PredPCF", bp_if.PredPCF, 32'hC4);
    chk("alias ok flushbp", bp_if.flushbp, 0);
    cyc(32'h300, 0, 0, 0);
    chk("alias flushbp", bp_if.flushbp, 0);
    // C16-C18: stale entry, decode says non-branch -> flush and invalidate
    cyc(32'h40, 0, 0, 0);
    cyc(32'h300, 0, 0, 0);
    chk("stale flushbp", bp_if.flushbp, 1);
    chk("stale RedirectPCD", bp_if.RedirectPCD, 32'h44);
    cyc(32'h40, 0, 0, 0);
    chk("stale HitF", bp_if.HitF, 0);
    // C19-C22: mispredicted branch held in decode for 3 stalled cycles
    for (int i = 0; i < 3; i++) begin
      cyc(32'h300, 1, 1, 32'h80, 1);
      chk("stall flushbp", bp_if.flushbp, 0);
    end
    cyc(32'h300, 1, 1, 32'h80);
    chk("release flushbp", bp_if.flushbp, 1);
    chk("release RedirectPCD", bp_if.RedirectPCD, 32'h80);
    cyc(32'h300, 0, 0, 0);
    chk("stall mc", bp_if.MispredCount, 6);
    chk("stall bc", bp_if.BranchCount, 8);

    // Reset with a resolution pending: discarded
    cyc(32'h300, 1, 1, 32'h80, 0, 0, 1);
    cyc(32'h40, 0, 0, 0, 0, 0, 1);
    cyc(32'h40, 0, 0, 0);
    chk("rst2 HitF", bp_if.HitF, 0);
    chk("rst2 bc", bp_if.BranchCount, 0);
    chk("rst2 mc", bp_if.MispredCount, 0);

    // Loop: branch at 0x100 back to 0xF0, taken 10 times then exits
    cyc(32'h100, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      cyc(32'hF0, 1, (i < 10), 32'hF0);
      cyc((i < 10) ? 32'h100 : 32'h300, 0, 0, 0);
    end
    chk("loop bc", bp_if.BranchCount, 11);
    chk("loop mc", bp_if.MispredCount, 2);

    // FlushD in a resolve cycle: update and count happen, new decode invalidated
    cyc(32'h100, 0, 0, 0);
    cyc(32'h300, 1, 0, 0, 0, 1);
    chk("flushd flushbp", bp_if.flushbp, 1);
    cyc(32'h300, 1, 1, 32'h80);
    chk("flushd idle flushbp", bp_if.flushbp, 0);
    cyc(32'h100, 0, 0, 0);
    chk("flushd bc", bp_if.BranchCount, 12);
    chk("flushd mc", bp_if.MispredCount, 3);
    chk("flushd HitF", bp_if.HitF, 1);
    chk("flushd PredTakenF", bp_if.PredTakenF, 0);
    cyc(32'h300, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
